// File: rtl/loom_pkg.sv
// Shared types and default widths for the loom run-control logic.
package loom_pkg;

    localparam int unsigned LOOM_CNT_W  = 64;
    localparam int unsigned LOOM_STEP_W = 32;

    typedef enum logic [1:0] {
        CMD_STOP = 2'd0,
        CMD_RUN  = 2'd1,
        CMD_STEP = 2'd2,
        CMD_CLR  = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } ctrl_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE      = 2'd0,
        CAUSE_CMD       = 2'd1,
        CAUSE_TRIG      = 2'd2,
        CAUSE_STEP_DONE = 2'd3
    } stop_cause_e;

endpackage

// File: rtl/loom_clk_ctrl.sv
// Run-control stage driving the emulation clock gate's CE input.
// Handles host stop/run/step/clear commands, breakpoint triggers and
// counts every gated clock edge.
module loom_clk_ctrl
    import loom_pkg::*;
#(
    parameter int unsigned CNT_W  = LOOM_CNT_W,
    parameter int unsigned STEP_W = LOOM_STEP_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [STEP_W-1:0] cmd_arg_i,
    input  logic              trig_i,
    output logic              ce_o,
    output logic [1:0]        state_o,
    output logic [CNT_W-1:0]  cycle_cnt_o,
    output logic              stop_evt_o,
    output logic [1:0]        stop_cause_o,
    output logic              cmd_err_o
);

    ctrl_state_e       state;
    stop_cause_e       stop_cause;
    cmd_op_e           op;
    logic [STEP_W-1:0] step_rem;
    logic              is_stop, is_run, is_step, is_clr;

    assign cmd_ready_o  = 1'b1;
    assign op           = cmd_op_e'(cmd_op_i);
    assign state_o      = state;
    assign stop_cause_o = stop_cause;

    assign is_stop = cmd_valid_i && (op == CMD_STOP);
    assign is_run  = cmd_valid_i && (op == CMD_RUN);
    assign is_step = cmd_valid_i && (op == CMD_STEP);
    assign is_clr  = cmd_valid_i && (op == CMD_CLR);

    // Run-control FSM; ce_o, stop event/cause and error pulse are registered here.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            ce_o       <= 1'b0;
            step_rem   <= '0;
            stop_evt_o <= 1'b0;
            stop_cause <= CAUSE_NONE;
            cmd_err_o  <= 1'b0;
        end else begin
            stop_evt_o <= 1'b0;
            cmd_err_o  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (is_run) begin
                        state <= ST_RUN;
                        ce_o  <= 1'b1;
                    end else if (is_step) begin
                        if (cmd_arg_i != '0) begin
                            state    <= ST_STEP;
                            step_rem <= cmd_arg_i;
                            ce_o     <= 1'b1;
                        end else begin
                            cmd_err_o <= 1'b1;
                        end
                    end
                end
                ST_RUN, ST_STEP: begin
                    if (state == ST_STEP && ce_o)
                        step_rem <= step_rem - STEP_W'(1);
                    if (is_step)
                        cmd_err_o <= 1'b1;
                    // Stop sources checked in priority order CMD > TRIG > STEP_DONE,
                    // so a single stop event carries the highest-ranked cause.
                    if (is_stop) begin
                        state      <= ST_IDLE;
                        ce_o       <= 1'b0;
                        stop_evt_o <= 1'b1;
                        stop_cause <= CAUSE_CMD;
                    end else if (trig_i) begin
                        state      <= ST_IDLE;
                        ce_o       <= 1'b0;
                        stop_evt_o <= 1'b1;
                        stop_cause <= CAUSE_TRIG;
                    end else if (state == ST_STEP && is_run) begin
                        state    <= ST_RUN;
                        step_rem <= '0;
                    end else if (state == ST_STEP && ce_o && step_rem == STEP_W'(1)) begin
                        state      <= ST_IDLE;
                        ce_o       <= 1'b0;
                        stop_evt_o <= 1'b1;
                        stop_cause <= CAUSE_STEP_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ce_o  <= 1'b0;
                end
            endcase
        end
    end

    // Gated-edge counter; CLR takes precedence over the edge in the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cycle_cnt_o <= '0;
        else if (is_clr)
            cycle_cnt_o <= '0;
        else if (ce_o)
            cycle_cnt_o <= cycle_cnt_o + CNT_W'(1);
    end

endmodule

// File: tb/tb_loom_clk_ctrl.sv
// Directed self-checking bench for loom_clk_ctrl.
module tb_loom_clk_ctrl;
    import loom_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'd0;
    logic [31:0] cmd_arg = '0;
    logic        trig = 1'b0;
    logic        cmd_ready, ce, stop_evt, cmd_err;
    logic [1:0]  state, stop_cause;
    logic [63:0] cycle_cnt;

    logic        c4_valid = 1'b0;
    logic [1:0]  c4_op = 2'd0;
    logic [31:0] c4_arg = '0;
    logic        c4_trig = 1'b0;
    logic        c4_ready, c4_ce, c4_evt, c4_err;
    logic [1:0]  c4_state, c4_cause;
    logic [3:0]  c4_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    loom_clk_ctrl dut (
        .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_op_i(cmd_op), .cmd_arg_i(cmd_arg), .trig_i(trig), .ce_o(ce),
        .state_o(state), .cycle_cnt_o(cycle_cnt), .stop_evt_o(stop_evt),
        .stop_cause_o(stop_cause), .cmd_err_o(cmd_err)
    );

    loom_clk_ctrl #(.CNT_W(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .cmd_valid_i(c4_valid), .cmd_ready_o(c4_ready),
        .cmd_op_i(c4_op), .cmd_arg_i(c4_arg), .trig_i(c4_trig), .ce_o(c4_ce),
        .state_o(c4_state), .cycle_cnt_o(c4_cnt), .stop_evt_o(c4_evt),
        .stop_cause_o(c4_cause), .cmd_err_o(c4_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        tick();
        cmd_valid = 1'b0;
        cmd_arg   = '0;
    endtask

    task automatic issue4(input logic [1:0] op);
        c4_valid = 1'b1;
        c4_op    = op;
        tick();
        c4_valid = 1'b0;
    endtask

    // Counts cycles with ce high (including the current one) and stop pulses over a bounded window.
    task automatic run_window(input int max, output int ce_n, output int evt_n);
        ce_n  = int'(ce);
        evt_n = 0;
        repeat (max) begin
            tick();
            ce_n  += int'(ce);
            evt_n += int'(stop_evt);
        end
    endtask

    int ce_n, evt_n;

    initial begin
        repeat (2) tick();
        check("rst_ce", 64'(ce), 0);
        check("rst_state", 64'(state), 0);
        check("rst_cnt", cycle_cnt, 0);
        check("rst_cause", 64'(stop_cause), 0);
        check("rst_evt", 64'(stop_evt), 0);
        check("rst_err", 64'(cmd_err), 0);
        check("ready", 64'(cmd_ready), 1);
        rst = 1'b0;
        tick();

        // STEP 5
        issue(CMD_STEP, 5);
        check("step5_state", 64'(state), 2);
        run_window(20, ce_n, evt_n);
        check("step5_ce_cycles", 64'(ce_n), 5);
        check("step5_cnt", cycle_cnt, 5);
        check("step5_evts", 64'(evt_n), 1);
        check("step5_cause", 64'(stop_cause), 3);
        check("step5_state_end", 64'(state), 0);

        // CLR in IDLE, then RUN stopped by trigger
        issue(CMD_CLR, 0);
        check("clr_idle_cnt", cycle_cnt, 0);
        check("clr_idle_state", 64'(state), 0);
        issue(CMD_RUN, 0);
        check("run_ce", 64'(ce), 1);
        repeat (10) tick();
        check("run10_cnt", cycle_cnt, 10);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        check("trig_ce", 64'(ce), 0);
        check("trig_cnt", cycle_cnt, 11);
        check("trig_cause", 64'(stop_cause), 2);
        check("trig_evt", 64'(stop_evt), 1);
        tick();
        check("trig_evt_clear", 64'(stop_evt), 0);
        check("trig_cnt_hold", cycle_cnt, 11);

        // STEP 100, STOP with coincident trigger: CMD wins
        issue(CMD_CLR, 0);
        issue(CMD_STEP, 100);
        repeat (20) tick();
        check("step100_cnt20", cycle_cnt, 20);
        trig = 1'b1;
        issue(CMD_STOP, 0);
        trig = 1'b0;
        check("cmdwin_cause", 64'(stop_cause), 1);
        check("cmdwin_cnt", cycle_cnt, 21);
        check("cmdwin_ce", 64'(ce), 0);
        check("cmdwin_evt", 64'(stop_evt), 1);

        // Error cases and no-ops
        issue(CMD_CLR, 0);
        issue(CMD_STEP, 0);
        check("step0_err", 64'(cmd_err), 1);
        check("step0_state", 64'(state), 0);
        check("step0_ce", 64'(ce), 0);
        tick();
        check("step0_err_clear", 64'(cmd_err), 0);
        issue(CMD_STOP, 0);
        check("idle_stop_evt", 64'(stop_evt), 0);
        check("idle_stop_cause", 64'(stop_cause), 1);
        issue(CMD_RUN, 0);
        issue(CMD_STEP, 7);
        check("runstep_err", 64'(cmd_err), 1);
        check("runstep_state", 64'(state), 1);
        check("runstep_ce", 64'(ce), 1);
        tick();
        check("runstep_err_clear", 64'(cmd_err), 0);
        issue(CMD_STOP, 0);
        check("runstop_state", 64'(state), 0);

        // RUN cmd converts STEP to RUN
        issue(CMD_STEP, 2);
        issue(CMD_RUN, 0);
        repeat (4) tick();
        check("step2run_state", 64'(state), 1);
        check("step2run_ce", 64'(ce), 1);
        issue(CMD_STOP, 0);

        // STEP 1 entered with trigger high: one edge, TRIG beats STEP_DONE
        issue(CMD_CLR, 0);
        trig = 1'b1;
        issue(CMD_STEP, 1);
        check("step1trig_ce_on", 64'(ce), 1);
        tick();
        trig = 1'b0;
        check("step1trig_ce_off", 64'(ce), 0);
        check("step1trig_cause", 64'(stop_cause), 2);
        check("step1trig_cnt", cycle_cnt, 1);

        // 4-bit counter wrap and CLR mid-run
        issue4(CMD_RUN);
        repeat (17) tick();
        issue4(CMD_STOP);
        check("wrap_cnt", 64'(c4_cnt), 2);
        check("wrap_cause", 64'(c4_cause), 1);
        issue4(CMD_RUN);
        repeat (3) tick();
        check("pre_clr_cnt", 64'(c4_cnt), 5);
        issue4(CMD_CLR);
        check("midclr_cnt", 64'(c4_cnt), 0);
        check("midclr_ce", 64'(c4_ce), 1);
        tick();
        check("postclr_cnt", 64'(c4_cnt), 1);
        issue4(CMD_STOP);

        // Async reset mid-STEP
        issue(CMD_STEP, 50);
        repeat (3) tick();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_ce", 64'(ce), 0);
        check("arst_state", 64'(state), 0);
        check("arst_cnt", cycle_cnt, 0);
        check("arst_cause", 64'(stop_cause), 0);
        check("arst_evt", 64'(stop_evt), 0);
        check("arst_err", 64'(cmd_err), 0);
        tick();
        rst = 1'b0;
        tick();
        issue(CMD_STEP, 3);
        run_window(10, ce_n, evt_n);
        check("post_rst_ce_cycles", 64'(ce_n), 3);
        check("post_rst_cnt", cycle_cnt, 3);
        check("post_rst_cause", 64'(stop_cause), 3);
        check("post_rst_evts", 64'(evt_n), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/loom_clk_ctrl.md
Name: loom_clk_ctrl

Overview:
- Run-control stage directly upstream of the emulation clock gate. Its ce_o drives the gate's CE input.
- Accepts host commands (stop, run, step N, clear counter) over a valid/ready port.
- Stops the design clock on a breakpoint trigger.
- Counts every gated (emulated) clock edge so software can read exact cycle position.

Parameters:
- CNT_W, 64, width of gated-cycle counter.
- STEP_W, 32, width of step-count argument and remaining-step counter.

Ports:
- clk_i  in  1  free-running clock; same clock as the gate's clk_in.
- rst_i  in  1  asynchronous, active-high reset.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command ready; tied high, every command is taken on valid.
- cmd_op_i  in  2  0=STOP, 1=RUN, 2=STEP, 3=CLR.
- cmd_arg_i  in  STEP_W  step count for STEP; ignored otherwise.
- trig_i  in  1  level breakpoint request.
- ce_o  out  1  registered clock enable to the gate.
- state_o  out  2  0=IDLE, 1=RUN, 2=STEP.
- cycle_cnt_o  out  CNT_W  gated-edge count.
- stop_evt_o  out  1  one-cycle pulse on entry to IDLE from RUN or STEP.
- stop_cause_o  out  2  1=CMD, 2=TRIG, 3=STEP_DONE; holds until the next stop.
- cmd_err_o  out  1  one-cycle pulse when a command is ignored.

Behaviour:
- Reset (async, immediate): state=IDLE; ce_o=0; cycle_cnt_o=0; step_rem=0; stop_evt_o=0; stop_cause_o=0; cmd_err_o=0.
- Reset during RUN or STEP drops ce_o at once; no further gated edges occur.
- ce_o is a flop.
  - Each clk_i cycle with ce_o=1 yields exactly one gated edge, because the gate latches CE during the low phase.
  - cycle_cnt_o increments by 1 on every rising edge where ce_o=1. It wraps from 2^CNT_W-1 to 0.
- A command is accepted on a rising edge where cmd_valid_i=1. There is no backpressure.
- IDLE state:
  - RUN: go to RUN; ce_o=1 from the next cycle.
  - STEP with N>0: go to STEP; step_rem=N; ce_o=1 from the next cycle.
  - STEP with N=0: stay in IDLE; pulse cmd_err_o.
  - STOP: no-op; no stop_evt_o.
  - trig_i is ignored in IDLE.
- RUN state:
  - STOP cmd: go to IDLE; ce_o=0 next cycle; cause=CMD.
  - trig_i=1 sampled: go to IDLE; ce_o=0 next cycle; cause=TRIG.
  - STEP cmd: ignored; pulse cmd_err_o.
  - RUN cmd: no-op.
- STEP state:
  - step_rem decrements on each edge with ce_o=1.
  - When ce_o=1 and step_rem==1: go to IDLE; ce_o=0 next cycle; cause=STEP_DONE. Net effect: ce_o is high for exactly N cycles.
  - RUN cmd converts to RUN and discards step_rem.
  - STOP cmd and trig_i behave as in RUN.
  - STEP cmd: ignored; pulse cmd_err_o.
- Stop priority when events coincide: CMD > TRIG > STEP_DONE. Only one stop_evt_o pulse is produced.
- Trigger latency: trig_i sampled at edge t gives ce_o=0 at t+1. The edge counted at t stands.
- RUN/STEP entered while trig_i is already high: ce_o=1 for one cycle (one gated edge), then stop with cause TRIG.
- CLR, any state:
  - cycle_cnt_o=0 on the next cycle, and the edge in the same cycle is not counted.
  - State, ce_o and step_rem are unchanged.
- stop_evt_o and stop_cause_o update in the same cycle that ce_o falls.

Decomposition:
- Shared package loom_pkg holds:
  - cmd_op_e (STOP/RUN/STEP/CLR);
  - ctrl_state_e (IDLE/RUN/STEP);
  - stop_cause_e (NONE/CMD/TRIG/STEP_DONE);
  - default widths.
- Single module, no sub-modules. Instantiated alongside the gate in the emulation wrapper.

Test Plan:
- Reset, then STEP arg=5: ce_o high exactly 5 cycles; cycle_cnt_o=5; stop_evt_o one pulse; stop_cause_o=3; state_o=0.
- RUN, trig_i raised 10 cycles after ce_o rises: ce_o falls on the following cycle; cycle_cnt_o=11; stop_cause_o=2.
- STEP arg=100, STOP after 20 gated cycles, with trig_i=1 in the same cycle: stop_cause_o=1 (CMD wins); cycle_cnt_o=21.
- STEP arg=0 and STEP issued during RUN: cmd_err_o pulses; state_o and ce_o unchanged.
- CNT_W=4, run 18 cycles then STOP: cycle_cnt_o wraps and reads 2. CLR mid-run: count resets to 0, ce_o stays 1.
- rst_i asserted mid-STEP (async, off-edge): ce_o=0 immediately; all outputs at reset values; next STEP arg=3 gives exactly 3 gated cycles.
